// File: rtl/pio_in_edge_irq.sv
// -----------------------------------------------------------------------------
// pio_in_edge_irq
//
// Avalon-MM slave input PIO. An external input bus is brought into the clk
// domain through a flop synchronizer and can be read back as a register.
// Each bit has a sticky edge-capture flag, and a level interrupt is raised
// while any captured edge is enabled in the interrupt mask.
//
// Register map (word addresses):
//   0 : data          read  -> synchronized in_port, writes ignored
//   1 : reserved      read  -> 0, writes ignored
//   2 : irq mask      read/write
//   3 : edge capture  read, write-1-to-clear
//
// Ports:
//   clk         system clock (single domain)
//   reset_n     asynchronous active-low reset
//   address     register select
//   chipselect  slave select, qualifies write_n
//   write_n     active-low write strobe
//   writedata   write data
//   in_port     external input bus, asynchronous to clk
//   readdata    registered read data, fixed latency of one cycle
//   irq         registered level interrupt, active high
//
// Parameters:
//   WIDTH        active register width (1..32); upper readdata bits read 0
//   EDGE_TYPE    0 = rising, 1 = falling, 2 = any edge
//   SYNC_STAGES  synchronizer depth (2..3)
// -----------------------------------------------------------------------------
module pio_in_edge_irq #(
  parameter int WIDTH       = 32,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  // Edge mode encodings.
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;

  // Flops in front of the named sync stage. Depth is clamped to the legal
  // 2..3 range so an out-of-range parameter still yields a working chain.
  localparam int META_STAGES = (SYNC_STAGES <= 2) ? 1 : 2;

  // Register addresses.
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // Synchronizer and edge-detect history.
  logic [WIDTH-1:0] meta_q [META_STAGES];
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;

  // Control/status state.
  logic [WIDTH-1:0] irq_mask_q;
  logic [WIDTH-1:0] irq_mask_d;
  logic [WIDTH-1:0] edge_capture_q;
  logic [WIDTH-1:0] edge_capture_d;

  // Registered outputs.
  logic [31:0]      readdata_q;
  logic [31:0]      readdata_d;
  logic             irq_q;
  logic             irq_d;

  // Combinational helpers.
  logic             wr_s;
  logic [WIDTH-1:0] edge_s;
  logic [WIDTH-1:0] clear_s;
  logic [WIDTH-1:0] read_mux_s;

  assign wr_s = chipselect & ~write_n;

  // Synchronizer chain; prev follows sync one cycle behind for edge detect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < META_STAGES; i++) begin
        meta_q[i] <= '0;
      end
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q[0] <= in_port;
      for (int i = 1; i < META_STAGES; i++) begin
        meta_q[i] <= meta_q[i-1];
      end
      sync_q <= meta_q[META_STAGES-1];
      prev_q <= sync_q;
    end
  end

  // Per-bit edge detection in the selected mode.
  always_comb begin
    edge_s = '0;
    case (EDGE_TYPE)
      EDGE_RISE: edge_s = sync_q & ~prev_q;
      EDGE_FALL: edge_s = ~sync_q & prev_q;
      default:   edge_s = sync_q ^ prev_q;
    endcase
  end

  // Mask write and write-1-to-clear of edge capture. A new edge is OR-ed in
  // after the clear so a same-cycle clear can never drop it.
  always_comb begin
    irq_mask_d = irq_mask_q;
    clear_s    = '0;
    if (wr_s && (address == ADDR_MASK)) begin
      irq_mask_d = writedata[WIDTH-1:0];
    end else begin
      irq_mask_d = irq_mask_q;
    end
    if (wr_s && (address == ADDR_EDGE)) begin
      clear_s = writedata[WIDTH-1:0];
    end else begin
      clear_s = '0;
    end
    edge_capture_d = (edge_capture_q & ~clear_s) | edge_s;
  end

  // Read mux; chipselect is deliberately ignored since reads have no side
  // effects and readdata is refreshed every cycle.
  always_comb begin
    read_mux_s = '0;
    case (address)
      ADDR_DATA: read_mux_s = sync_q;
      ADDR_RSVD: read_mux_s = '0;
      ADDR_MASK: read_mux_s = irq_mask_q;
      ADDR_EDGE: read_mux_s = edge_capture_q;
      default:   read_mux_s = '0;
    endcase
    readdata_d               = '0;
    readdata_d[WIDTH-1:0]    = read_mux_s;
    irq_d                    = |(edge_capture_q & irq_mask_q);
  end

  // Control/status registers and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask_q     <= '0;
      edge_capture_q <= '0;
      readdata_q     <= 32'd0;
      irq_q          <= 1'b0;
    end else begin
      irq_mask_q     <= irq_mask_d;
      edge_capture_q <= edge_capture_d;
      readdata_q     <= readdata_d;
      irq_q          <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
